// File: rtl/board_line_fetcher.sv
// board_line_fetcher: prefetches one board row from the shared RAM read port
// into a double-buffered line buffer for the VGA cell display. The CPU always
// owns the port when it asks for it; fetch reads fill the cycles it leaves free.
module board_line_fetcher #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_WIDTH = 12,
  parameter int CELL_BITS  = 3,
  parameter int RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  row_start,
  input  logic [4:0]            row_idx,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [CELL_BITS-1:0]  mem_rdata,
  input  logic [3:0]            rd_col,
  output logic [CELL_BITS-1:0]  rd_cell,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;  // column tag width
  localparam int CCW = $clog2(COLS + 1);               // capture count width

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_SWAP  = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [4:0]                  row_lat_q, row_lat_d;
  logic [CIW-1:0]              issue_col_q, issue_col_d;
  logic [CCW-1:0]              cap_cnt_q, cap_cnt_d;
  logic [RD_LAT-1:0]           vld_q, vld_d;
  logic [RD_LAT-1:0][CIW-1:0]  tag_q, tag_d;
  logic                        front_sel_q, front_sel_d;
  logic                        err_q, err_d;
  logic [CELL_BITS-1:0]        buf_q [2][COLS];
  logic [CELL_BITS-1:0]        buf_d [2][COLS];

  logic [ADDR_WIDTH-1:0]       fetch_addr;
  logic                        issue;
  logic                        row_ok;
  logic                        reject;
  logic                        capture;
  logic [CIW-1:0]              cap_tag;
  logic                        back_sel;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_SWAP);
  assign err      = err_q;
  assign issue    = (state_q == S_ISSUE) && !cpu_req;
  assign row_ok   = (32'(row_idx) < ROWS);
  assign reject   = row_start && (busy || !row_ok);
  assign capture  = vld_q[RD_LAT-1];
  assign cap_tag  = tag_q[RD_LAT-1];
  assign back_sel = ~front_sel_q;

  // Fetch address of the next cell to issue; wraps modulo the address space.
  always_comb begin
    fetch_addr = ADDR_WIDTH'(BASE_ADDR)
               + ADDR_WIDTH'(row_lat_q) * ADDR_WIDTH'(COLS)
               + ADDR_WIDTH'(issue_col_q);
  end

  // RAM port mux: the fetcher only drives the address when the CPU is idle.
  always_comb begin
    mem_addr = issue ? fetch_addr : cpu_addr;
  end

  // Display read from the front buffer; out-of-row columns read as 0.
  always_comb begin
    if (32'(rd_col) < COLS) rd_cell = buf_q[front_sel_q][CIW'(rd_col)];
    else                    rd_cell = '0;
  end

  // Valid/tag pipeline matching the RAM read latency.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = issue;
    tag_d[0] = issue_col_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Returning cells land in the back buffer; the front is only touched by swap.
  always_comb begin
    buf_d = buf_q;
    if (capture) buf_d[back_sel][cap_tag] = mem_rdata;
  end

  // Fetch sequencer, capture counter, front select and sticky error.
  always_comb begin
    state_d     = state_q;
    row_lat_d   = row_lat_q;
    issue_col_d = issue_col_q;
    cap_cnt_d   = cap_cnt_q;
    front_sel_d = front_sel_q;

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (reject)  err_d = 1'b1;  // a set in the same cycle beats the clear

    if (capture) cap_cnt_d = cap_cnt_q + CCW'(1);

    case (state_q)
      S_IDLE: begin
        if (row_start && row_ok) begin
          state_d     = S_ISSUE;
          row_lat_d   = row_idx;
          issue_col_d = '0;
          cap_cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          issue_col_d = issue_col_q + CIW'(1);
          if (issue_col_q == CIW'(COLS - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Counting this cycle's capture lets the swap follow the last word directly.
        if (cap_cnt_d == CCW'(COLS)) begin
          state_d     = S_SWAP;
          front_sel_d = ~front_sel_q;  // display sees the new row while done is high
        end
      end
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any fetch and blanks both buffers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_lat_q   <= '0;
      issue_col_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
      tag_q       <= '0;
      front_sel_q <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: the line buffers are reset because the display must read 0 after reset, not stale cells.
      buf_q       <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      row_lat_q   <= row_lat_d;
      issue_col_q <= issue_col_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      front_sel_q <= front_sel_d;
      err_q       <= err_d;
      buf_q       <= buf_d;
    end
  end

endmodule

// File: tb/tb_board_line_fetcher.sv
// Directed bench for board_line_fetcher: reset, clean fetch, contention,
// bad row, abort and overrun, against a registered-read RAM model.
module tb_board_line_fetcher;

  localparam int COLS = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        row_start = 1'b0;
  logic [4:0]  row_idx = '0;
  logic        cpu_req = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [11:0] mem_addr;
  logic [2:0]  mem_rdata;
  logic [3:0]  rd_col = '0;
  logic [2:0]  rd_cell;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr = 1'b0;

  logic [2:0]  ram [4096];
  logic [2:0]  row3_exp [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

  int n_checks = 0;
  int n_pass   = 0;

  board_line_fetcher dut (
    .clock     (clock),
    .reset     (reset),
    .row_start (row_start),
    .row_idx   (row_idx),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rd_col    (rd_col),
    .rd_cell   (rd_cell),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clock = ~clock;

  // RAM with one cycle of read latency.
  always @(posedge clock) mem_rdata <= ram[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Front buffer must hold row 3; columns past the row read 0. Ends on a negedge.
  task automatic check_front(input string tag);
    for (int c = 0; c < COLS; c++) begin
      rd_col = 4'(c);
      #1;
      check(tag, 32'(rd_cell), 32'(row3_exp[c]));
    end
    rd_col = 4'd12;
    #1;
    check({tag, "_col12"}, 32'(rd_cell), 32'd0);
    rd_col = 4'd15;
    #1;
    check({tag, "_col15"}, 32'(rd_cell), 32'd0);
    rd_col = 4'd0;
    @(negedge clock);
  endtask

  // Row-3 fetch from a negedge; cpu_req high in cycles cont_lo..cont_hi,
  // a row-5 request in cycle ovr_cyc (0 = none), done expected in exp_done.
  task automatic run_fetch(input int cont_lo, input int cont_hi, input int ovr_cyc, input int exp_done);
    int n;
    n = 0;
    row_start = 1'b1;
    row_idx   = 5'd3;
    cpu_req   = 1'b0;
    cpu_addr  = 12'h7A5;
    rd_col    = 4'd0;
    @(negedge clock);
    for (int k = 1; k <= exp_done; k++) begin
      cpu_req   = (k >= cont_lo) && (k <= cont_hi);
      cpu_addr  = cpu_req ? 12'h123 : 12'h7A5;
      row_start = (k == ovr_cyc);
      row_idx   = (k == ovr_cyc) ? 5'd5 : 5'd3;
      #1;
      if (!cpu_req && n < COLS) begin
        check("fetch_addr", 32'(mem_addr), 32'(30 + n));
        n++;
      end else begin
        check("cpu_addr_pass", 32'(mem_addr), 32'(cpu_addr));
      end
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == exp_done));
      check("err", 32'(err), 32'(ovr_cyc > 0 && k > ovr_cyc));
      if (k == exp_done) check("rd_cell_at_done", 32'(rd_cell), 32'(row3_exp[0]));
      @(negedge clock);
    end
    row_start = 1'b0;
    cpu_req   = 1'b0;
    #1;
    check("idle_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 3'd6;
    for (int c = 0; c < COLS; c++) ram[30 + c] = row3_exp[c];

    // 1. Reset held with random inputs.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      row_start = 1'($urandom);
      row_idx   = 5'($urandom);
      cpu_req   = 1'($urandom);
      cpu_addr  = 12'($urandom);
      err_clr   = 1'($urandom);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c);
      #1;
      check("rst_rd_cell", 32'(rd_cell), 32'd0);
    end
    @(negedge clock);
    reset     = 1'b1;
    row_start = 1'b0;
    err_clr   = 1'b0;
    rd_col    = 4'd0;
    for (int k = 0; k < 4; k++) begin
      cpu_req  = 1'($urandom);
      cpu_addr = 12'($urandom);
      #1;
      check("idle_mem_addr", 32'(mem_addr), 32'(cpu_addr));
      @(negedge clock);
    end

    // 2. Clean fetch: done in cycle 12.
    run_fetch(0, 0, 0, 12);
    check_front("clean_front");

    // 3. Contention in cycles 4..7: done in cycle 16.
    run_fetch(4, 7, 0, 16);
    check_front("contention_front");

    // 5. Bad row while idle.
    row_start = 1'b1;
    row_idx   = 5'd20;
    @(negedge clock);
    row_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cpu_req  = 1'(k % 2);
      cpu_addr = 12'(100 + 7 * k);
      #1;
      check("badrow_busy", 32'(busy), 32'd0);
      check("badrow_mem_addr", 32'(mem_addr), 32'(cpu_addr));
      check("badrow_err", 32'(err), 32'd1);
      @(negedge clock);
    end
    cpu_req = 1'b0;
    check_front("badrow_front");

    // 6. Abort by reset in cycle 6 of a fetch, then a clean refetch.
    row_start = 1'b1;
    row_idx   = 5'd3;
    @(negedge clock);
    row_start = 1'b0;
    for (int k = 1; k < 6; k++) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_rd_cell", 32'(rd_cell), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_fetch(0, 0, 0, 12);
    check_front("abort_refetch_front");

    // 4. Overrun: row-5 request in cycle 3 of a row-3 fetch.
    run_fetch(0, 0, 3, 12);
    #1;
    check("overrun_err_sticky", 32'(err), 32'd1);
    check_front("overrun_front");
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    @(negedge clock);
    // Clear and set in the same cycle: the set wins.
    err_clr   = 1'b1;
    row_start = 1'b1;
    row_idx   = 5'd20;
    @(negedge clock);
    err_clr   = 1'b0;
    row_start = 1'b0;
    #1;
    check("err_set_wins", 32'(err), 32'd1);
    check("set_wins_busy", 32'(busy), 32'd0);
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
